// File: rtl/arm_cortex_m0p_pkg.sv
// Shared core package: data width, ALU operation encoding and the
// multiply-sequencer state type.
package arm_cortex_m0p_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SHL,
    ALU_SHR,
    ALU_PASS_B
  } alu_op_t;

  // Operation presented to the shared ALU whenever the sequencer does not own it.
  localparam alu_op_t ALU_IDLE_OP = ALU_AND;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_RUN,
    MS_DONE
  } ms_state_t;

endpackage

// File: rtl/alu.sv
// Core's shared combinational ALU; lives in the datapath and is borrowed by
// the multiply sequencer while alu_busy is high.
module alu
  import arm_cortex_m0p_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             z,
  output logic             n
);

  localparam int SHW = $clog2(WIDTH);

  always_comb begin
    r = '0;
    unique case (op)
      ALU_ADD:    r = a + b;
      ALU_SUB:    r = a - b;
      ALU_AND:    r = a & b;
      ALU_OR:     r = a | b;
      ALU_XOR:    r = a ^ b;
      ALU_SHL:    r = a << b[SHW-1:0];
      ALU_SHR:    r = a >> b[SHW-1:0];
      ALU_PASS_B: r = b;
      default:    r = '0;
    endcase
  end

  assign z = (r == '0);
  assign n = r[WIDTH-1];

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-add multiply sequencer: one accumulation per cycle through the
// shared ALU, returning the low WIDTH bits of a*b with Z/N flags.
//
// state   | meaning
// MS_IDLE | ready for a request; ALU not owned
// MS_RUN  | one shift-add step per cycle using the shared ALU
// MS_DONE | result and flags held until the consumer takes them
module alu_mul_seq
  import arm_cortex_m0p_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_z,
  output logic             rsp_n,
  output logic             alu_busy,
  output alu_op_t          alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_r
);

  ms_state_t        state, state_nxt;
  logic [WIDTH-1:0] p, m, q;
  logic [WIDTH-1:0] q_shr;

  assign q_shr      = {1'b0, q[WIDTH-1:1]};
  assign rsp_result = p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MS_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ALU-facing outputs depend only on registered state, never on req_* inputs.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_busy  = 1'b0;
    alu_op    = ALU_IDLE_OP;
    alu_a     = '0;
    alu_b     = '0;
    case (state)
      MS_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = MS_RUN;
      end
      MS_RUN: begin
        alu_busy = 1'b1;
        alu_op   = ALU_ADD;
        alu_a    = p;
        alu_b    = q[0] ? m : '0;
        if (q_shr == '0) state_nxt = MS_DONE;
      end
      MS_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = MS_IDLE;
      end
      default: state_nxt = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p     <= '0;
      m     <= '0;
      q     <= '0;
      rsp_z <= 1'b0;
      rsp_n <= 1'b0;
    end else begin
      case (state)
        MS_IDLE: begin
          if (req_valid) begin
            p <= '0;
            m <= req_a;
            q <= req_b;
          end
        end
        MS_RUN: begin
          p <= alu_r;
          m <= m << 1;
          q <= q_shr;
          // Flags come from the final accumulation, not the ALU's own flags.
          if (q_shr == '0) begin
            rsp_z <= (alu_r == '0);
            rsp_n <= alu_r[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq wired to the shared ALU: directed vector table,
// hand-written handshake/reset sequences and random operands vs a product model.
module tb_alu_mul_seq;
  import arm_cortex_m0p_pkg::*;

  localparam int W = DATA_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready;
  logic [W-1:0] req_a, req_b;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_z, rsp_n;
  logic         alu_busy;
  alu_op_t      alu_op;
  logic [W-1:0] alu_a, alu_b, alu_r;
  logic         alu_z, alu_n;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] bseq[$];
  int           op_bad;
  bit           idle_ok;

  always #5 clk = ~clk;

  alu_mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_z(rsp_z), .rsp_n(rsp_n),
    .alu_busy(alu_busy), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r)
  );

  alu #(.WIDTH(W)) u_alu (
    .op(alu_op), .a(alu_a), .b(alu_b), .r(alu_r), .z(alu_z), .n(alu_n)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_result;
    logic         exp_z;
    logic         exp_n;
    int           exp_cycles;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int model_cycles(input logic [W-1:0] b);
    int n = 1;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  function automatic logic [W-1:0] model_product(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] full;
    full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return full[W-1:0];
  endfunction

  task automatic wait_rsp(output bit ok);
    int guard = 0;
    while (!rsp_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    ok = rsp_valid;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: rsp_valid never rose");
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output logic z, output logic n,
                        output int cyc);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready stayed low");
    end
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
    cyc       = 0;
    op_bad    = 0;
    bseq.delete();
    guard     = 0;
    @(negedge clk);
    while (!rsp_valid && guard < 200) begin
      if (alu_busy) begin
        cyc++;
        bseq.push_back(alu_b);
        if (alu_op != ALU_ADD) op_bad++;
      end
      @(negedge clk);
      guard++;
    end
    if (!rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: no response for a=0x%0h b=0x%0h", a, b);
    end
    res     = rsp_result;
    z       = rsp_z;
    n       = rsp_n;
    idle_ok = !alu_busy && alu_a == '0 && alu_b == '0 && alu_op == ALU_AND;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    vec_t         vecs[8];
    logic [W-1:0] res;
    logic         z, n;
    int           cyc;
    bit           ok, stable, seen;

    vecs[0] = '{32'd7,        32'd6,        32'd42,       1'b0, 1'b0, 3};
    vecs[1] = '{32'h1234,     32'd0,        32'd0,        1'b1, 1'b0, 1};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        1'b0, 1'b0, 32};
    vecs[3] = '{32'h80000000, 32'd1,        32'h80000000, 1'b0, 1'b1, 1};
    vecs[4] = '{32'd3,        32'd5,        32'd15,       1'b0, 1'b0, 3};
    vecs[5] = '{32'd1,        32'd1,        32'd1,        1'b0, 1'b0, 1};
    vecs[6] = '{32'hFFFF,     32'h10000,    32'hFFFF0000, 1'b0, 1'b1, 17};
    vecs[7] = '{32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b0, 1'b1, 2};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #12;
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_alu_busy", alu_busy, 0);
    check("reset_alu_a", alu_a, 0);
    check("reset_alu_b", alu_b, 0);
    check("reset_alu_op", alu_op, ALU_AND);
    check("reset_result", rsp_result, 0);
    check("reset_flags", {rsp_z, rsp_n}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, res, z, n, cyc);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp_result);
      check($sformatf("vec%0d_z", i), z, vecs[i].exp_z);
      check($sformatf("vec%0d_n", i), n, vecs[i].exp_n);
      check($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cycles);
      check($sformatf("vec%0d_op_add", i), op_bad, 0);
      check($sformatf("vec%0d_idle_alu", i), idle_ok, 1);
      if (i == 0) begin
        check("basic_bseq_len", bseq.size(), 3);
        if (bseq.size() == 3) begin
          check("basic_bseq0", bseq[0], 0);
          check("basic_bseq1", bseq[1], 14);
          check("basic_bseq2", bseq[2], 28);
        end
      end
    end

    // Backpressure: result holds, no accept while busy, then accept right after handshake.
    @(negedge clk);
    req_a = 32'd3; req_b = 32'd5; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    wait_rsp(ok);
    req_valid = 1'b1; req_a = 32'd2; req_b = 32'd4;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (!(rsp_valid && rsp_result == 32'd15 && !rsp_z && !rsp_n && !req_ready && !alu_busy))
        stable = 1'b0;
      @(negedge clk);
    end
    check("bp_stable", stable, 1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("bp_ready_after_hs", req_ready, 1);
    check("bp_no_rsp_after_hs", rsp_valid, 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("bp_next_accept", alu_busy, 1);
    @(negedge clk);
    wait_rsp(ok);
    check("bp_next_result", rsp_result, 32'd8);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;

    // Reset in the fourth RUN cycle aborts with no response.
    @(negedge clk);
    req_a = 32'd1; req_b = 32'hFFFF; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    check("mid_busy_before", alu_busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_req_ready", req_ready, 1);
    check("mid_alu_busy", alu_busy, 0);
    check("mid_result", rsp_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("mid_no_rsp", seen, 0);
    run_op(32'd2, 32'd3, res, z, n, cyc);
    check("mid_after_result", res, 32'd6);

    // Random operands, multiplier length varied by a random right shift.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb, er;
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (i % 8 == 3) ra = -ra;
      er = model_product(ra, rb);
      run_op(ra, rb, res, z, n, cyc);
      check($sformatf("rnd%0d_result", i), res, er);
      check($sformatf("rnd%0d_flags", i), {z, n}, {er == '0, er[W-1]});
      check($sformatf("rnd%0d_cycles", i), cyc, model_cycles(rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle multiply sequencer that computes the low DATA_WIDTH bits of a × b with a shift-add algorithm. It borrows the core's single shared ALU for every accumulation step. It sits beside the execute stage: decode hands it a MULS request, and while `alu_busy` is high the datapath routes the ALU operands from this block. It returns the product plus Z/N flags through a valid/ready response.

## Interface
Parameters:
- `WIDTH`, default `DATA_WIDTH` (package, 32). Operand, result and ALU width.

Ports:
- `clk`, input, 1. Single clock, rising edge.
- `rst_n`, input, 1. Reset, asynchronous, active-low.
- `req_valid`, input, 1. Multiply request present.
- `req_ready`, output, 1. Block can accept; equals (state == MS_IDLE).
- `req_a`, input, WIDTH. Multiplicand; sampled only on the accept edge.
- `req_b`, input, WIDTH. Multiplier; sampled only on the accept edge.
- `rsp_valid`, output, 1. Result available; equals (state == MS_DONE).
- `rsp_ready`, input, 1. Consumer takes the result.
- `rsp_result`, output, WIDTH. Product modulo 2^WIDTH.
- `rsp_z`, output, 1. Z flag: `rsp_result == 0`.
- `rsp_n`, output, 1. N flag: `rsp_result[WIDTH-1]`.
- `alu_busy`, output, 1. High in MS_RUN; the datapath grants the ALU to this block.
- `alu_op`, output, `alu_op_t`. Operation driven to the shared ALU.
- `alu_a`, output, WIDTH. ALU operand a.
- `alu_b`, output, WIDTH. ALU operand b.
- `alu_r`, input, WIDTH. ALU result, combinational within the same cycle.

## Operation
- Registers:
  - P: accumulator.
  - M: shifted multiplicand.
  - Q: remaining multiplier.
  - `rsp_z`/`rsp_n` flag registers.
  - `state`: `ms_state_t`.
- **MS_IDLE**
  - `req_ready`=1.
  - On `req_valid`: P←0, M←`req_a`, Q←`req_b`; go to MS_RUN.
- **MS_RUN**, one iteration per cycle:
  - `alu_op`=ALU_ADD, `alu_a`=P, `alu_b`=(Q[0] ? M : 0).
  - P←`alu_r`, M←M<<1, Q←Q>>1.
  - If next Q (Q>>1) == 0: go to MS_DONE. Z/N are registered from the next P (`alu_r`), so they match the final result.
  - Iteration count N = max(1, index of the highest set bit of `req_b` + 1). N is at most WIDTH by construction.
- **MS_DONE**
  - `rsp_valid`=1; `rsp_result`=P, held stable with the flags.
  - On `rsp_ready`: go to MS_IDLE.
- Outside MS_RUN: `alu_op`=ALU_AND, `alu_a`=`alu_b`=0, `alu_busy`=0.
- **Arithmetic**
  - Unsigned shift-add. The low WIDTH bits equal the two's-complement signed product.
  - Carries out of bit WIDTH-1 are discarded; M shifts off the top silently.
- Flags are derived from P inside this block, never from the ALU flag outputs.

## Timing
- **Reset values** (asynchronous clear on `rst_n`=0):
  - State MS_IDLE; P, M, Q = 0; `rsp_z`=0, `rsp_n`=0.
  - Outputs: `req_ready`=1, `rsp_valid`=0, `rsp_result`=0, `alu_busy`=0, `alu_op`=ALU_AND, `alu_a`=`alu_b`=0.
- **Latency**
  - Accept at edge E0; `rsp_valid` rises after edge E0+N.
  - Total accept-to-`rsp_valid` latency is N cycles: minimum 1 (b ≤ 1), maximum WIDTH (b MSB set).
- **Throughput**
  - `req_ready` is low from the accept edge until the `rsp_ready` handshake edge.
  - The earliest next accept is the cycle after the response handshake.
  - Only one operation is ever in flight; there is no pending-request buffering.
- **Held signals**
  - `req_a`/`req_b` changes after accept have no effect.
  - `req_valid` asserted while not ready is ignored; it is not queued.
- **Response stability:** `rsp_valid`, `rsp_result`, `rsp_z` and `rsp_n` are stable until the `rsp_ready` handshake.
- **ALU combinational path:** `alu_r` must settle within the same cycle. `alu_busy`/`alu_op`/`alu_a`/`alu_b` are decoded from registered state with no combinational input-to-output path, except through `alu_r`.
- **Reset mid-operation:** reset in MS_RUN or MS_DONE aborts the operation. No response is produced and the block returns to reset values immediately.

## Structure
- Add to `arm_cortex_m0p_pkg`:
  - `ms_state_t` enum {MS_IDLE, MS_RUN, MS_DONE}.
  - `ALU_IDLE_OP` localparam = ALU_AND.
- `alu_op_t` and `DATA_WIDTH` are reused from the package unchanged.
- No sub-module. The ALU is instantiated in the datapath, which muxes its operands on `alu_busy`.
- The bench instantiates `alu_mul_seq` together with a real `alu`.

## Test plan
- **Reset:** hold `rst_n`=0 → `req_ready`=1, `rsp_valid`=0, `alu_busy`=0, `alu_a`=`alu_b`=0, `rsp_result`=0.
- **Basic multiply:** a=7, b=6 → 3 RUN cycles with `alu_busy`=1 and `alu_op`=ALU_ADD, `alu_b` sequence 0,14,28 → `rsp_result`=42, z=0, n=0, `rsp_valid` 3 cycles after accept.
- **Zero multiplier:** a=0x1234, b=0 → exactly 1 RUN cycle, `rsp_result`=0, z=1, n=0.
- **Extreme operands:**
  - a=b=0xFFFFFFFF → 32 RUN cycles, `rsp_result`=0x00000001, n=0.
  - a=0x80000000, b=1 → 1 cycle, result 0x80000000, n=1.
- **Backpressure:** a=3, b=5 with `rsp_ready` held low for 5 cycles → result 15 stable, `req_ready`=0, and a concurrent `req_valid` is not accepted. After the handshake, a new request is accepted on the following cycle.
- **Reset mid-run:** a=1, b=0xFFFF; assert `rst_n`=0 in RUN cycle 4 → immediate MS_IDLE, no `rsp_valid` pulse. A subsequent request 2×3 returns 6.
